// File: rtl/uart_tx_if.sv
// Byte handshake carrying console writes into the buffered UART transmitter.
// A byte moves on any clock edge where tx_valid and tx_ready are both high.
interface uart_tx_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO feeding an LSB-first serialiser (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_if.slave                   tx,
    output logic                       uart_tx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int DIV     = CLK_FREQ / BAUD;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2:0]         idx_q;
    logic [2:0]         idx_d;
    logic [7:0]         shift_q;
    logic [7:0]         shift_d;
    logic               line_q;
    logic               line_d;
    logic               bit_end;
    logic               pop;
    logic               push;
    logic               fifo_empty;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
`ifdef UART_TX_PARITY_EN
    logic               par_q;
    logic               par_d;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    assign fifo_empty = (count_q == '0);
    assign tx.tx_ready = (count_q != COUNT_W'(DEPTH));
    assign push       = tx.tx_valid && tx.tx_ready;
    assign bit_end    = (cnt_q == CNT_W'(DIV - 1));
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign fifo_count = count_q;
    assign uart_tx    = line_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        line_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(mem[rd_ptr_q]);
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Reload straight from the stop bit so queued frames leave no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        par_d   = even_parity(mem[rd_ptr_q]);
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line is registered from the next state so the pad never sees decode glitches.
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_d = par_d;
`endif
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            line_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage and shift data carry no reset; a flush is done purely through pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx.tx_data;
        end
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-schedule reference model checked every cycle, plus a line decoder.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 25000000;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 16;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS    = 11;
`else
    localparam int NBITS    = 10;
`endif
    localparam int FRAME    = NBITS * DIV;
    localparam int CW       = $clog2(DEPTH + 1);

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    uart_tx_if txif ();

    uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (txif.slave),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #20 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    byte_q_t    mq;
    byte_q_t    dq;
    bit         act      = 1'b0;
    int         fs       = 0;
    logic [7:0] fb       = 8'h00;
    bit         last_push;
    bit         dec_on   = 1'b0;
    int         dec_t0   = 0;
    logic [7:0] dec_b    = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Line level expected after edge e, from the frame that began at edge fs.
    function automatic logic exp_line(input int e);
        int k;
        if (!act || e >= fs + FRAME) return 1'b1;
        k = (e - fs) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return fb[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^fb;
`endif
        return 1'b1;
    endfunction

    task automatic decode(input logic rst_s);
        int off;
        int k;
        if (rst_s) return;
        if (!dec_on) begin
            if (uart_tx === 1'b0) begin
                dec_on = 1'b1;
                dec_t0 = cyc;
            end
        end else begin
            off = cyc - dec_t0;
            if (off % DIV == DIV / 2) begin
                k = off / DIV;
                if (k >= 1 && k <= 8) begin
                    dec_b[k-1] = uart_tx;
                end else if (k == NBITS - 1) begin
                    chk("stop_bit", 32'(uart_tx), 32'd1);
                    dq.push_back(dec_b);
                    dec_on = 1'b0;
                end
            end
        end
    endtask

    // One clock: model the edge from the inputs it sees, then compare all outputs.
    task automatic tick();
        logic       rst_s;
        logic       vld_s;
        logic [7:0] dat_s;
        int         sz;
        bit         can_push;
        bit         can_pop;
        @(posedge clk);
        cyc++;
        rst_s     = rst;
        vld_s     = txif.tx_valid;
        dat_s     = txif.tx_data;
        last_push = 1'b0;
        if (rst_s) begin
            mq.delete();
            act    = 1'b0;
            dec_on = 1'b0;
        end else begin
            sz       = mq.size();
            can_push = vld_s && (sz != DEPTH);
            can_pop  = (sz != 0) && (!act || cyc >= fs + FRAME);
            if (can_pop) begin
                fb  = mq.pop_front();
                fs  = cyc;
                act = 1'b1;
            end
            if (can_push) begin
                mq.push_back(dat_s);
                last_push = 1'b1;
            end
        end
        #1;
        chk("uart_tx", 32'(uart_tx), 32'(exp_line(cyc)));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("tx_ready", 32'(txif.tx_ready), 32'(mq.size() != DEPTH));
        chk("busy", 32'(busy), 32'((act && cyc < fs + FRAME) || mq.size() != 0));
        decode(rst_s);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_dec(input string tag, input byte_q_t exp);
        chk({tag, "_len"}, 32'(dq.size()), 32'(exp.size()));
        for (int i = 0; i < dq.size() && i < exp.size(); i++) begin
            chk(tag, 32'(dq[i]), 32'(exp[i]));
        end
        dq.delete();
    endtask

    initial begin
        #(40 * 120000);
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t    exp;
        logic [7:0] b;
        logic [7:0] extra;
        int         base;
        int         n0;
        int         waited;

        txif.tx_valid = 1'b0;
        txif.tx_data  = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single 0x55 frame.
        txif.tx_valid = 1'b1;
        txif.tx_data  = 8'h55;
        tick();
        txif.tx_valid = 1'b0;
        txif.tx_data  = 8'($urandom);
        run(FRAME + 20);
        exp = '{8'h55};
        chk_dec("frame_55", exp);

        // "A\n" back to back.
        txif.tx_valid = 1'b1;
        txif.tx_data  = 8'h41;
        tick();
        txif.tx_data  = 8'h0A;
        tick();
        txif.tx_valid = 1'b0;
        run(2 * FRAME + 20);
        exp = '{8'h41, 8'h0A};
        chk_dec("frame_A_nl", exp);

        // Overflow: 20 offers, 17 fit; then refill on the full-FIFO pop edge.
        base = int'($urandom_range(0, 255));
        exp.delete();
        n0 = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            txif.tx_valid = 1'b1;
            txif.tx_data  = 8'(base + i);
            tick();
            if (i < 17) exp.push_back(8'(base + i));
        end
        txif.tx_valid = 1'b0;
        chk("full_count", 32'(fifo_count), 32'(DEPTH));
        chk("full_ready", 32'(txif.tx_ready), 32'd0);
        run(n0 + FRAME - 3 - cyc);
        extra = 8'(base + 100);
        txif.tx_valid = 1'b1;
        txif.tx_data  = extra;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!last_push && waited < 40);
        txif.tx_valid = 1'b0;
        chk("refill_count", 32'(fifo_count), 32'(DEPTH));
        chk("refill_ready", 32'(txif.tx_ready), 32'd0);
        exp.push_back(extra);
        run(17 * FRAME + 40);
        chk_dec("overflow", exp);

        // Reset mid-DATA of a 0x00 frame with another byte queued.
        txif.tx_valid = 1'b1;
        txif.tx_data  = 8'h00;
        tick();
        txif.tx_data  = 8'hA5;
        tick();
        txif.tx_valid = 1'b0;
        run(3 * DIV);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        run(FRAME + 20);
        exp.delete();
        chk_dec("after_reset", exp);

`ifdef UART_TX_PARITY_EN
        txif.tx_valid = 1'b1;
        txif.tx_data  = 8'h07;
        tick();
        txif.tx_data  = 8'h03;
        tick();
        txif.tx_valid = 1'b0;
        run(2 * FRAME + 20);
        exp = '{8'h07, 8'h03};
        chk_dec("parity", exp);
`endif

        // Random bytes with random gaps; idle data lines carry junk.
        exp.delete();
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom);
            txif.tx_valid = 1'b1;
            txif.tx_data  = b;
            tick();
            if (last_push) exp.push_back(b);
            txif.tx_valid = 1'b0;
            txif.tx_data  = 8'($urandom);
            run(int'($urandom_range(0, 400)));
        end
        run(6 * FRAME + 20);
        chk_dec("random", exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
